// File: rtl/cpu_pkg.sv
// Shared CPU front-end widths and the fetch buffer payload.
package cpu_pkg;

   localparam int unsigned ADDR_W     = 64;
   localparam int unsigned INST_W     = 32;
   localparam int unsigned INST_BYTES = 4;

   // One fetched instruction tagged with the PC it was read from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t head,
   output logic         head_valid,
   output logic         full
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   fetch_entry_t     storage [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   // Entry storage; cleared on reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            storage[i] <= '0;
         end
      end else if (push && !flush) begin
         storage[wr_ptr] <= wr_entry;
      end
   end

   // Pointers wrap naturally since the depth is a power of two; flush rewinds both.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head       = storage[rd_ptr];
   assign head_valid = (count != CNT_W'(0));
   assign full       = (count == CNT_W'(FIFO_DEPTH));

endmodule : fetch_fifo

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, buffers {pc, inst} for decode.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MEM_BYTES  = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fetch_enable,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] imem_address,
   input  logic [INST_W-1:0] imem_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              fetch_fault
);

   // Highest PC whose whole word still lies inside instruction memory.
   localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(MEM_BYTES - INST_BYTES);

   logic [ADDR_W-1:0] pc;
   logic              fault;
   logic              fifo_full;
   logic              head_valid;
   fetch_entry_t      head;
   fetch_entry_t      wr_entry;
   logic              pop_c;
   logic              fetch_req_c;
   logic              push_c;
   logic              unused_redirect_lsbs;

   // Push/pop decisions; an out-of-range fetch request raises the fault instead of pushing.
   always_comb begin
      pop_c       = head_valid & inst_ready;
      fetch_req_c = fetch_enable & ~redirect_valid & ~fault & (~fifo_full | pop_c);
      push_c      = fetch_req_c & (pc <= PC_LIMIT);
   end

   // PC and sticky fault; redirect wins over everything else.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc    <= RESET_PC;
         fault <= 1'b0;
      end else if (redirect_valid) begin
         pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
         fault <= 1'b0;
      end else if (push_c) begin
         pc    <= pc + ADDR_W'(INST_BYTES);
      end else if (fetch_req_c) begin
         fault <= 1'b1;
      end
   end

   assign wr_entry = '{pc: pc, inst: imem_data};

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (redirect_valid),
      .push       (push_c),
      .pop        (pop_c),
      .wr_entry   (wr_entry),
      .head       (head),
      .head_valid (head_valid),
      .full       (fifo_full)
   );

   assign imem_address         = pc;
   assign inst_valid           = head_valid;
   assign inst_data            = head.inst;
   assign inst_pc              = head.pc;
   assign fetch_fault          = fault;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus queues expected handshakes, a monitor checks them.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_enable;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] imem_address;
   logic [31:0] imem_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;
   logic        fetch_fault;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] imem [64];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .fetch_enable   (fetch_enable),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_address   (imem_address),
      .imem_data      (imem_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .fetch_fault    (fetch_fault)
   );

   // Bench memory contents: four program words, then a tagged filler pattern.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [5:0] idx;
      idx = a[7:2];
      case (idx)
         6'd0:    return 32'h8b1f03e5;
         6'd1:    return 32'hf84000a4;
         6'd2:    return 32'h8b040086;
         6'd3:    return 32'hf80010a6;
         default: return 32'hC0DE_0000 | 32'(idx);
      endcase
   endfunction

   assign imem_data = (imem_address < 64'd256) ? imem[imem_address[7:2]] : 32'hDEAD_BEEF;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_fetch(input logic [63:0] a);
      exp_t e;
      e.pc   = a;
      e.inst = mem_word(a);
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n        = 1'b0;
      fetch_enable   = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      tick();
      tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      reset_n = 1'b1;
      check("rst_valid", 64'(inst_valid), 64'd0);
      check("rst_pc", imem_address, 64'd0);
      check("rst_inst_pc", inst_pc, 64'd0);
      check("rst_inst_data", 64'(inst_data), 64'd0);
      check("rst_fault", 64'(fetch_fault), 64'd0);
   endtask

   // Straight stream right after reset release: four instructions accepted back to back.
   task automatic run_stream();
      fetch_enable = 1'b1;
      inst_ready   = 1'b1;
      expect_fetch(64'd0);
      expect_fetch(64'd4);
      expect_fetch(64'd8);
      expect_fetch(64'd12);
      tick();
      check("first_valid", 64'(inst_valid), 64'd1);
      check("first_pc", inst_pc, 64'd0);
      for (int i = 0; i < 4; i++) tick();
      inst_ready   = 1'b0;
      fetch_enable = 1'b0;
      check("stream_queue", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) imem[i] = mem_word(64'(i * 4));

      // Monitor: every accepted head must match the next expected fetch.
      fork
         forever begin
            @(negedge clk);
            if (reset_n && inst_valid && inst_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pop", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("pop_pc", inst_pc, e.pc);
                  check("pop_inst", 64'(inst_data), 64'(e.inst));
               end
            end
         end
         begin
            #200000;
            $display("FAIL watchdog: got timeout expected finish");
            $fatal(1, "watchdog");
         end
      join_none

      // 1: basic stream
      apply_reset();
      run_stream();

      // 2: back-pressure fills the FIFO, then drains in order
      apply_reset();
      fetch_enable = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("stall_pc", imem_address, 64'd8);
      check("stall_valid", 64'(inst_valid), 64'd1);
      check("stall_head_pc", inst_pc, 64'd0);
      check("stall_head_inst", 64'(inst_data), 64'h8b1f03e5);
      for (int i = 0; i < 4; i++) expect_fetch(64'(i * 4));
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      inst_ready   = 1'b0;
      fetch_enable = 1'b0;
      check("stall_queue", 64'(exp_q.size()), 64'd0);

      // 3: redirect with a full FIFO; handshake in the redirect cycle completes
      apply_reset();
      fetch_enable = 1'b1;
      tick();
      tick();
      check("redir_pre_pc", imem_address, 64'd8);
      expect_fetch(64'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h0000_0000_0000_000E;
      inst_ready     = 1'b1;
      tick();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      check("redir_flush_valid", 64'(inst_valid), 64'd0);
      check("redir_pc", imem_address, 64'd12);
      tick();
      check("redir_head_valid", 64'(inst_valid), 64'd1);
      check("redir_head_pc", inst_pc, 64'd12);
      check("redir_head_inst", 64'(inst_data), 64'hf80010a6);
      expect_fetch(64'd12);
      inst_ready = 1'b1;
      tick();
      inst_ready   = 1'b0;
      fetch_enable = 1'b0;
      check("redir_queue", 64'(exp_q.size()), 64'd0);

      // 4: fetch at the last legal word, then fault at the memory limit
      apply_reset();
      fetch_enable   = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'd252;
      tick();
      redirect_valid = 1'b0;
      check("lim_pc", imem_address, 64'd252);
      tick();
      check("lim_pushed", 64'(inst_pc), 64'd252);
      check("lim_no_fault", 64'(fetch_fault), 64'd0);
      check("lim_pc_next", imem_address, 64'd256);
      tick();
      check("fault_set", 64'(fetch_fault), 64'd1);
      tick();
      tick();
      check("fault_pc_hold", imem_address, 64'd256);
      check("fault_sticky", 64'(fetch_fault), 64'd1);
      expect_fetch(64'd252);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("fault_drained", 64'(inst_valid), 64'd0);
      tick();
      check("fault_no_push", 64'(inst_valid), 64'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 64'd0;
      tick();
      redirect_valid = 1'b0;
      fetch_enable   = 1'b0;
      check("fault_cleared", 64'(fetch_fault), 64'd0);
      check("fault_redir_pc", imem_address, 64'd0);
      check("fault_queue", 64'(exp_q.size()), 64'd0);

      // 5: asynchronous reset between edges, then clean restart
      apply_reset();
      fetch_enable = 1'b1;
      inst_ready   = 1'b1;
      expect_fetch(64'd0);
      expect_fetch(64'd4);
      tick();
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 64'(inst_valid), 64'd0);
      check("arst_pc", imem_address, 64'd0);
      check("arst_inst_pc", inst_pc, 64'd0);
      fetch_enable = 1'b0;
      inst_ready   = 1'b0;
      tick();
      check("arst_queue", 64'(exp_q.size()), 64'd0);
      reset_n = 1'b1;
      run_stream();

      // 6: full FIFO with push and pop every cycle
      apply_reset();
      fetch_enable = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 10; k++) expect_fetch(64'(k * 4));
      inst_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("full_pp_pc", imem_address, 64'(8 + 4 * (i + 1)));
      end
      inst_ready = 1'b0;
      tick();
      check("full_pp_hold", imem_address, 64'd48);
      check("full_pp_head", inst_pc, 64'd40);
      fetch_enable = 1'b0;
      check("full_pp_queue", 64'(exp_q.size()), 64'd0);

      tick();
      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_instruction_fetch_unit
